// File: rtl/multicore_debug_cmd_dispatch.sv
// System-clock side of the shared multicore JTAG debug slave.
// Synchronises the update-DR / update-IR strobes into clk, queues each scanned
// command {channel, IR, data} in a small FIFO and presents the head command to
// the addressed debug channel over a one-hot valid / per-channel ready handshake.
module multicore_debug_cmd_dispatch #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned SR_W       = 38,
    parameter int unsigned IR_W       = 2,
    parameter int unsigned SYNC_DEPTH = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vs_udr,
    input  logic              vs_uir,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [SR_W-1:0]   sr,
    input  logic [CH_W-1:0]   ch_sel,
    output logic [NUM_CH-1:0] cmd_valid,
    input  logic [NUM_CH-1:0] cmd_ready,
    output logic [IR_W-1:0]   cmd_ir,
    output logic [SR_W-1:0]   cmd_data,
    output logic              uir_pulse,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    output logic              bad_ch,
    input  logic              err_clr
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned ENT_W = CH_W + IR_W + SR_W;
    localparam int unsigned CHK_W = CH_W + 1;

    logic [SYNC_DEPTH-1:0] udr_sync;
    logic [SYNC_DEPTH-1:0] uir_sync;
    logic                  udr_prev;
    logic                  uir_prev;
    logic                  udr_pulse;

    logic [ENT_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr_nxt;

    logic                  ch_ok;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop_bad;
    logic                  drop_ovf;
    logic [LVL_W-1:0]      remain;
    logic [LVL_W-1:0]      level_nxt;
    logic [ENT_W-1:0]      new_entry;
    logic [ENT_W-1:0]      head_nxt;
    logic [CH_W-1:0]       head_ch_nxt;
    logic [IR_W-1:0]       head_ir_nxt;
    logic [SR_W-1:0]       head_data_nxt;
    logic [NUM_CH-1:0]     valid_nxt;

    // Strobe synchronisers with rising-edge detect; udr rise is registered once more
    // so the push happens SYNC_DEPTH+1 edges after the strobe is first sampled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync  <= '0;
            uir_sync  <= '0;
            udr_prev  <= 1'b0;
            uir_prev  <= 1'b0;
            udr_pulse <= 1'b0;
            uir_pulse <= 1'b0;
        end else begin
            udr_sync  <= {udr_sync[SYNC_DEPTH-2:0], vs_udr};
            uir_sync  <= {uir_sync[SYNC_DEPTH-2:0], vs_uir};
            udr_prev  <= udr_sync[SYNC_DEPTH-1];
            uir_prev  <= uir_sync[SYNC_DEPTH-1];
            udr_pulse <= udr_sync[SYNC_DEPTH-1] & ~udr_prev;
            uir_pulse <= uir_sync[SYNC_DEPTH-1] & ~uir_prev;
        end
    end

    // Push/pop decisions and look-ahead of the head entry after this edge, so the
    // registered outputs already show the new head in the cycle following a pop
    // (or the bypassed new entry when it lands in an empty queue).
    always_comb begin
        ch_ok      = ({1'b0, ch_sel} < CHK_W'(NUM_CH));
        full       = (fifo_level == LVL_W'(FIFO_DEPTH));
        pop        = |(cmd_valid & cmd_ready);
        push       = udr_pulse & ch_ok & (~full | pop);
        drop_bad   = udr_pulse & ~ch_ok;
        drop_ovf   = udr_pulse & ch_ok & full & ~pop;
        rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        remain     = fifo_level - LVL_W'(pop);
        level_nxt  = remain + LVL_W'(push);
        new_entry  = {ch_sel, ir_in, sr};
        head_nxt   = (remain == '0) ? new_entry : mem[rd_ptr_nxt];
        {head_ch_nxt, head_ir_nxt, head_data_nxt} = head_nxt;
        valid_nxt  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            valid_nxt[i] = (level_nxt != '0) && (head_ch_nxt == CH_W'(i));
        end
    end

    // Queue pointers, level, registered head outputs and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            cmd_valid  <= '0;
            cmd_ir     <= '0;
            cmd_data   <= '0;
            overflow   <= 1'b0;
            bad_ch     <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            fifo_level <= level_nxt;
            cmd_valid  <= valid_nxt;
            if (level_nxt != '0) begin
                cmd_ir   <= head_ir_nxt;
                cmd_data <= head_data_nxt;
            end
            overflow   <= drop_ovf | (overflow & ~err_clr);
            bad_ch     <= drop_bad | (bad_ch & ~err_clr);
        end
    end

    // Command storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

endmodule

// File: tb/tb_multicore_debug_cmd_dispatch.sv
// Self-checking bench for multicore_debug_cmd_dispatch: directed scenarios plus a
// randomized run compared cycle by cycle against a queue-based reference model.
module tb_multicore_debug_cmd_dispatch;

    localparam int unsigned NUM_CH = 5;
    localparam int unsigned SR_W   = 38;
    localparam int unsigned IR_W   = 2;
    localparam int unsigned S      = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned LVL_W  = 3;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
    } ent_t;

    logic              clk;
    logic              reset_n;
    logic              vs_udr;
    logic              vs_uir;
    logic [IR_W-1:0]   ir_in;
    logic [SR_W-1:0]   sr;
    logic [CH_W-1:0]   ch_sel;
    logic [NUM_CH-1:0] cmd_valid;
    logic [NUM_CH-1:0] cmd_ready;
    logic [IR_W-1:0]   cmd_ir;
    logic [SR_W-1:0]   cmd_data;
    logic              uir_pulse;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;
    logic              bad_ch;
    logic              err_clr;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    ent_t              mq[$];
    logic              udr_h [S+3];
    logic              uir_h [S+3];
    logic [NUM_CH-1:0] m_valid;
    logic [IR_W-1:0]   m_ir;
    logic [SR_W-1:0]   m_data;
    logic [LVL_W-1:0]  m_level;
    logic              m_ovf;
    logic              m_bad;
    logic              m_uir;

    multicore_debug_cmd_dispatch #(
        .NUM_CH(NUM_CH),
        .SR_W(SR_W),
        .IR_W(IR_W),
        .SYNC_DEPTH(S),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .vs_udr(vs_udr),
        .vs_uir(vs_uir),
        .ir_in(ir_in),
        .sr(sr),
        .ch_sel(ch_sel),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir),
        .cmd_data(cmd_data),
        .uir_pulse(uir_pulse),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .bad_ch(bad_ch),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [SR_W-1:0] rnd_data();
        return SR_W'({$urandom(), $urandom()});
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < S + 3; i++) begin
            udr_h[i] = 1'b0;
            uir_h[i] = 1'b0;
        end
        m_valid = '0;
        m_ir    = '0;
        m_data  = '0;
        m_level = '0;
        m_ovf   = 1'b0;
        m_bad   = 1'b0;
        m_uir   = 1'b0;
    endtask

    // One clock edge: the model samples the inputs at the edge the DUT sees,
    // then returns 1 ns later when DUT outputs are settled.
    task automatic step();
        logic pop, push, set_bad, set_ovf;
        ent_t e;
        @(posedge clk);
        for (int i = S + 2; i > 0; i--) begin
            udr_h[i] = udr_h[i-1];
            uir_h[i] = uir_h[i-1];
        end
        udr_h[0] = vs_udr;
        uir_h[0] = vs_uir;
        pop     = (mq.size() > 0) && cmd_ready[mq[0].ch];
        push    = 1'b0;
        set_bad = 1'b0;
        set_ovf = 1'b0;
        e.ch    = ch_sel;
        e.ir    = ir_in;
        e.data  = sr;
        // command arrives S+1 edges after the strobe was first sampled high
        if (udr_h[S+1] && !udr_h[S+2]) begin
            if (32'(ch_sel) >= NUM_CH) set_bad = 1'b1;
            else if (mq.size() == int'(DEPTH) && !pop) set_ovf = 1'b1;
            else push = 1'b1;
        end
        if (pop) mq.delete(0);
        if (push) mq.push_back(e);
        m_bad   = set_bad | (m_bad & ~err_clr);
        m_ovf   = set_ovf | (m_ovf & ~err_clr);
        m_uir   = uir_h[S] & ~uir_h[S+1];
        m_level = LVL_W'(mq.size());
        m_valid = '0;
        if (mq.size() > 0) begin
            m_valid[mq[0].ch] = 1'b1;
            m_ir   = mq[0].ir;
            m_data = mq[0].data;
        end
        #1;
    endtask

    task automatic drive_cmd(input logic [CH_W-1:0] ch, input logic [IR_W-1:0] ir,
                             input logic [SR_W-1:0] d);
        ch_sel = ch;
        ir_in  = ir;
        sr     = d;
        vs_udr = 1'b1;
        step();
        vs_udr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (cmd_valid !== '0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", cmd_valid); end
        n_tests++; if (cmd_ir !== '0) begin n_fail++; $display("FAIL reset_ir: got %b want 0", cmd_ir); end
        n_tests++; if (cmd_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", cmd_data); end
        n_tests++; if (uir_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_uir: got %b want 0", uir_pulse); end
        n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        n_tests++; if (bad_ch !== 1'b0) begin n_fail++; $display("FAIL reset_bad: got %b want 0", bad_ch); end
        model_reset();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [SR_W-1:0] d;
        d = 38'h15_5555_5555;
        cmd_ready = '1;
        drive_cmd(3'd2, 2'b01, d);
        repeat (S) step();
        n_tests++; if (cmd_valid !== '0) begin n_fail++; $display("FAIL single_early: got %b want 0", cmd_valid); end
        step();
        n_tests++; if (cmd_valid !== 5'b00100) begin n_fail++; $display("FAIL single_valid: got %b want 00100", cmd_valid); end
        n_tests++; if (cmd_ir !== 2'b01) begin n_fail++; $display("FAIL single_ir: got %b want 01", cmd_ir); end
        n_tests++; if (cmd_data !== d) begin n_fail++; $display("FAIL single_data: got %h want %h", cmd_data, d); end
        n_tests++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level1: got %0d want 1", fifo_level); end
        step();
        n_tests++; if (cmd_valid !== '0) begin n_fail++; $display("FAIL single_popped: got %b want 0", cmd_valid); end
        n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL single_level0: got %0d want 0", fifo_level); end
        n_tests++; if (cmd_data !== d) begin n_fail++; $display("FAIL single_hold: got %h want %h", cmd_data, d); end
    endtask

    task automatic test_overflow();
        logic [SR_W-1:0] sent [5];
        cmd_ready = '0;
        for (int k = 0; k < 5; k++) begin
            sent[k] = rnd_data();
            drive_cmd(3'd0, IR_W'(k), sent[k]);
            repeat (4) step();
        end
        n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        cmd_ready = '1;
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (cmd_valid !== 5'b00001 || cmd_data !== sent[k])
                begin n_fail++; $display("FAIL ovf_order%0d: got %b/%h want 00001/%h", k, cmd_valid, cmd_data, sent[k]); end
            step();
        end
        n_tests++; if (fifo_level !== '0 || cmd_valid !== '0)
            begin n_fail++; $display("FAIL ovf_drained: got level %0d valid %b want 0/0", fifo_level, cmd_valid); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_back_to_back_full();
        logic [SR_W-1:0] sent [4];
        logic [SR_W-1:0] expq [4];
        logic [SR_W-1:0] newd;
        cmd_ready = '0;
        for (int k = 0; k < 4; k++) begin
            sent[k] = rnd_data();
            drive_cmd(3'd3, 2'b10, sent[k]);
            repeat (4) step();
        end
        newd = rnd_data();
        drive_cmd(3'd3, 2'b11, newd);
        repeat (S) step();
        cmd_ready = 5'b01000;
        step();
        cmd_ready = '0;
        n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_pp_level: got %0d want 4", fifo_level); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pp_ovf: got %b want 0", overflow); end
        expq[0] = sent[1]; expq[1] = sent[2]; expq[2] = sent[3]; expq[3] = newd;
        cmd_ready = '1;
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (cmd_valid !== 5'b01000 || cmd_data !== expq[k])
                begin n_fail++; $display("FAIL full_pp_order%0d: got %b/%h want 01000/%h", k, cmd_valid, cmd_data, expq[k]); end
            step();
        end
        n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL full_pp_drain: got %0d want 0", fifo_level); end
    endtask

    task automatic test_bad_ch();
        logic saw_valid;
        saw_valid = 1'b0;
        cmd_ready = '1;
        drive_cmd(3'd5, 2'b01, rnd_data());
        for (int k = 0; k < int'(S) + 2; k++) begin
            step();
            if (cmd_valid !== '0) saw_valid = 1'b1;
        end
        n_tests++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL bad_valid: got 1 want 0"); end
        n_tests++; if (bad_ch !== 1'b1) begin n_fail++; $display("FAIL bad_flag: got %b want 1", bad_ch); end
        n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL bad_level: got %0d want 0", fifo_level); end
        drive_cmd(3'd6, 2'b00, rnd_data());
        repeat (S) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_tests++; if (bad_ch !== 1'b1) begin n_fail++; $display("FAIL bad_set_prio: got %b want 1", bad_ch); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_tests++; if (bad_ch !== 1'b0) begin n_fail++; $display("FAIL bad_clear: got %b want 0", bad_ch); end
    endtask

    task automatic test_uir_glitch();
        int pulses;
        pulses = 0;
        vs_uir = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 10) vs_uir = 1'b0;
            step();
            if (uir_pulse === 1'b1) pulses++;
        end
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL uir_once: got %0d pulses want 1", pulses); end
        cmd_ready = '0;
        ch_sel = 3'd1;
        ir_in  = 2'b10;
        sr     = rnd_data();
        // glitch entirely between edges
        vs_udr = 1'b1;
        #2;
        vs_udr = 1'b0;
        repeat (S + 3) step();
        n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL glitch_missed: got %0d want 0", fifo_level); end
        // glitch straddling one edge
        #6;
        vs_udr = 1'b1;
        step();
        #1;
        vs_udr = 1'b0;
        repeat (S + 6) step();
        n_tests++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL glitch_once: got %0d want 1", fifo_level); end
        n_tests++; if (cmd_valid !== 5'b00010) begin n_fail++; $display("FAIL glitch_valid: got %b want 00010", cmd_valid); end
        cmd_ready = '1;
        repeat (2) step();
    endtask

    task automatic test_reset_mid();
        logic [SR_W-1:0] d;
        cmd_ready = '0;
        for (int k = 0; k < 3; k++) begin
            drive_cmd(3'd1, 2'b01, rnd_data());
            repeat (4) step();
        end
        n_tests++; if (cmd_valid !== 5'b00010 || fifo_level !== 3'd3)
            begin n_fail++; $display("FAIL rst_pre: got %b/%0d want 00010/3", cmd_valid, fifo_level); end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++; if (cmd_valid !== '0) begin n_fail++; $display("FAIL rst_async_valid: got %b want 0", cmd_valid); end
        n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL rst_async_level: got %0d want 0", fifo_level); end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        d = rnd_data();
        cmd_ready = '1;
        drive_cmd(3'd4, 2'b10, d);
        repeat (S + 1) step();
        n_tests++; if (cmd_valid !== 5'b10000 || cmd_ir !== 2'b10 || cmd_data !== d)
            begin n_fail++; $display("FAIL rst_after: got %b/%b/%h want 10000/10/%h", cmd_valid, cmd_ir, cmd_data, d); end
        step();
        n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL rst_after_pop: got %0d want 0", fifo_level); end
    endtask

    task automatic test_random();
        int hi, lo;
        for (int c = 0; c < 150; c++) begin
            ch_sel = ($urandom_range(0, 7) == 0) ? CH_W'($urandom_range(5, 7)) : CH_W'($urandom_range(0, 4));
            ir_in  = IR_W'($urandom());
            sr     = rnd_data();
            vs_udr = 1'b1;
            hi = $urandom_range(1, 3);
            lo = $urandom_range(S + 1, S + 4);
            for (int k = 0; k < hi + lo; k++) begin
                if (k == hi) vs_udr = 1'b0;
                cmd_ready = NUM_CH'($urandom());
                err_clr   = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 7) == 0) vs_uir = ~vs_uir;
                step();
                n_tests++; if (cmd_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, cmd_valid, m_valid); end
                n_tests++; if (cmd_ir !== m_ir) begin n_fail++; $display("FAIL rnd_ir c%0d: got %b want %b", c, cmd_ir, m_ir); end
                n_tests++; if (cmd_data !== m_data) begin n_fail++; $display("FAIL rnd_data c%0d: got %h want %h", c, cmd_data, m_data); end
                n_tests++; if (fifo_level !== m_level) begin n_fail++; $display("FAIL rnd_level c%0d: got %0d want %0d", c, fifo_level, m_level); end
                n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c%0d: got %b want %b", c, overflow, m_ovf); end
                n_tests++; if (bad_ch !== m_bad) begin n_fail++; $display("FAIL rnd_bad c%0d: got %b want %b", c, bad_ch, m_bad); end
                n_tests++; if (uir_pulse !== m_uir) begin n_fail++; $display("FAIL rnd_uir c%0d: got %b want %b", c, uir_pulse, m_uir); end
            end
        end
        err_clr = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        vs_udr    = 1'b0;
        vs_uir    = 1'b0;
        ir_in     = '0;
        sr        = '0;
        ch_sel    = '0;
        cmd_ready = '0;
        err_clr   = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back_full();
        test_bad_ch();
        test_uir_glitch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
